syscall_responder: RTL and testbench
====================================

# syscall_responder

Services `syscall` instructions flagged by the instruction decoder; it is the receiving end of the decoder's `syscall_en` strobe. On a syscall the register file already presents `$v0` on read port A and `$a0` on read port B; this block reads both. It halts the core, pauses it, or hands `$a0` to the display driver through a one-entry valid/ready buffer, stalling the PC when that buffer is full. It sits beside the PC register and drives the PC stall.

## Interface
- `DATA_W`, 32, width of `$v0`, `$a0` and display data
- `CNT_W`, 16, width of the retired-syscall counter
- `HALT_CODE`, 10, `$v0` value that halts the core
- `DISP_CODE`, 34, `$v0` value that displays `$a0`
- `PAUSE_CODE`, 50, `$v0` value that pauses the core (only with `SYSCALL_PAUSE_EN`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `syscall_en`  in  1  current instruction is `syscall`
- `v0`  in  DATA_W  register-file port A data (`$v0`)
- `a0`  in  DATA_W  register-file port B data (`$a0`)
- `resume`  in  1  one-cycle pulse that releases a pause
- `disp_ready`  in  1  display driver accepts `disp_data`
- `stall`  out  1  hold PC and suppress all writes this cycle
- `halted`  out  1  core permanently halted
- `disp_valid`  out  1  `disp_data` holds an unconsumed value
- `disp_data`  out  DATA_W  value to display
- `syscall_cnt`  out  CNT_W  count of retired syscalls

## Operation
- States: IDLE, PAUSED, HALTED. Reset: IDLE; `disp_valid`=0, `disp_data`=0, `syscall_cnt`=0, `halted`=0, `stall`=0.
- A syscall **retires** when `syscall_en`=1, state is IDLE, and `stall`=0 in the same cycle.
- Only retired syscalls act. Each retired syscall increments `syscall_cnt`, which wraps modulo 2^CNT_W.
- **Halt** (`v0`==HALT_CODE):
  - The syscall retires, so the PC advances past it.
  - Next state is HALTED. In HALTED, `halted`=1 and `stall`=1.
  - Only `rst` leaves HALTED. `resume` is ignored there.
- **Display** (`v0`==DISP_CODE):
  - The buffer accepts a value when `!disp_valid || disp_ready`.
  - On acceptance, `disp_data`←`a0` and `disp_valid`←1 at the next edge.
  - If the buffer cannot accept, `stall`=1 combinationally and the syscall does not retire. It is retried each cycle, since the PC stays on it.
- **Handshake:**
  - A transfer occurs on any edge where `disp_valid && disp_ready`.
  - If no new value loads on that edge, `disp_valid`←0.
  - If a transfer and a new load happen on the same edge, `disp_data` takes the new `a0` and `disp_valid` stays 1.
  - `disp_data` must not change while `disp_valid`=1 and `disp_ready`=0.
- **Other `$v0` values:** the syscall retires as a no-op; only the counter changes.
- While in PAUSED or HALTED, `syscall_en` is ignored.
- The display buffer keeps draining in every state.

## Timing
- `stall` is combinational:
  - 1 in IDLE only when `syscall_en` && `v0`==DISP_CODE && `disp_valid` && !`disp_ready`;
  - 1 in PAUSED and HALTED.
- Latencies:
  - Display data appears on `disp_data` 1 cycle after retirement.
  - `halted` rises 1 cycle after the halt syscall retires.
  - `stall` drops in the same cycle `disp_ready` rises on a blocked display.
- Reset dominates every other input, including a same-cycle `syscall_en` or `resume`.
- A `rst` asserted mid-handshake discards the buffered value.
- Counter wrap: from 2^CNT_W−1, the next retirement gives 0.

## Configuration
- Macro: `SYSCALL_PAUSE_EN`.
- **Defined:**
  - `v0`==PAUSE_CODE retires, and the next state is PAUSED with `stall`=1.
  - A `resume` pulse in PAUSED returns to IDLE at the next edge, so `stall`=0 the following cycle.
  - `resume` outside PAUSED is ignored.
- **Undefined:** PAUSED does not exist, PAUSE_CODE is an ordinary no-op, and `resume` is unused.

## Structure
- Syscall code defaults (`SYSCALL_HALT`, `SYSCALL_DISP`, `SYSCALL_PAUSE`) and the state encoding (`SYSC_ST_*`, 2 bits) go in `Core.vh` alongside the other shared `define`s.
- Sub-module `syscall_disp_buf`: one-entry valid/ready register.
  - Ports: `clk`, `rst`, `load`, `din`, `accept`, `valid`, `dout`, `ready`.
  - The top level drives `stall` from `accept`.

## Test plan
- **Display, driver always ready:** `syscall_en`=1, `v0`=34, `a0`=0x1234, `disp_ready`=1 → `stall`=0; next cycle `disp_valid`=1, `disp_data`=0x1234, `syscall_cnt`=1.
- **Back-pressure:** buffer holds 0xAAAA with `disp_ready`=0, then display syscall with `a0`=0xBBBB → `stall`=1 for 3 cycles and `disp_data` stays 0xAAAA; raise `disp_ready` → same-cycle `stall`=0, next cycle `disp_data`=0xBBBB, `disp_valid`=1.
- **Halt:** `v0`=10 → `stall`=0 in that cycle; then `halted`=1 and `stall`=1 for 100 cycles regardless of `resume`; `rst` → all outputs 0.
- **Pause** (`SYSCALL_PAUSE_EN` defined): `v0`=50 → `stall`=1 from next cycle; `resume` pulse at cycle 20 → `stall`=0 at cycle 21. Without the macro, `v0`=50 → no stall, count+1.
- **Counter wrap:** with `CNT_W`=4, retire 16 no-op syscalls (`v0`=7) → `syscall_cnt` reads 15 then 0.
- **Reset mid-handshake:** `disp_valid`=1, `disp_ready`=0, assert `rst` → next cycle `disp_valid`=0, `disp_data`=0, state IDLE.

Source files
------------

// File: rtl/syscall_responder_pkg.sv
// Shared syscall codes and state encoding for the syscall responder.
// The optional pause service is enabled with the SYSCALL_PAUSE_EN macro.
package syscall_responder_pkg;

   localparam int SYSCALL_HALT  = 10;
   localparam int SYSCALL_DISP  = 34;
   localparam int SYSCALL_PAUSE = 50;

   typedef enum logic [1:0] {
      SYSC_ST_IDLE   = 2'd0,
      SYSC_ST_PAUSED = 2'd1,
      SYSC_ST_HALTED = 2'd2
   } sysc_state_t;

endpackage

// File: rtl/syscall_disp_buf.sv
// One-entry valid/ready register feeding the display driver.
// A new load may overlap a transfer of the previous value on the same edge.
module syscall_disp_buf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic              accept,
   output logic              valid,
   output logic [DATA_W-1:0] dout,
   input  logic              ready
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   assign accept = !r_valid || ready;
   assign valid  = r_valid;
   assign dout   = r_data;

   // The held value only changes on a load, and a load is only legal when accept is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load && accept) begin
         r_valid <= 1'b1;
         r_data  <= din;
      end else if (r_valid && ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/syscall_responder.sv
// Services decoded syscalls: halt, display via a one-entry buffer, and
// (with SYSCALL_PAUSE_EN defined) pause until a resume pulse.
module syscall_responder
   import syscall_responder_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                CNT_W      = 16,
   parameter logic [DATA_W-1:0] HALT_CODE  = DATA_W'(SYSCALL_HALT),
   parameter logic [DATA_W-1:0] DISP_CODE  = DATA_W'(SYSCALL_DISP),
   parameter logic [DATA_W-1:0] PAUSE_CODE = DATA_W'(SYSCALL_PAUSE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              syscall_en,
   input  logic [DATA_W-1:0] v0,
   input  logic [DATA_W-1:0] a0,
   input  logic              resume,
   input  logic              disp_ready,
   output logic              stall,
   output logic              halted,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   output logic [CNT_W-1:0]  syscall_cnt
);

   sysc_state_t       r_state;
   sysc_state_t       w_nextState;
   logic [CNT_W-1:0]  r_syscallCnt;
   logic              w_accept;
   logic              w_retire;
   logic              w_isHalt;
   logic              w_isDisp;
   logic              w_isPause;

   assign w_isHalt = (v0 == HALT_CODE);
   assign w_isDisp = (v0 == DISP_CODE);
`ifdef SYSCALL_PAUSE_EN
   assign w_isPause = (v0 == PAUSE_CODE);
`else
   logic w_unusedPause;
   assign w_isPause     = 1'b0;
   assign w_unusedPause = &{1'b0, resume, PAUSE_CODE};
`endif

   assign w_retire = syscall_en && (r_state == SYSC_ST_IDLE) && !stall;

   syscall_disp_buf #(
      .DATA_W(DATA_W)
   ) u_dispBuf (
      .clk    (clk),
      .rst    (rst),
      .load   (w_retire && w_isDisp),
      .din    (a0),
      .accept (w_accept),
      .valid  (disp_valid),
      .dout   (disp_data),
      .ready  (disp_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SYSC_ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // HALTED is only left through reset; PAUSED only exists with the macro.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         SYSC_ST_IDLE: begin
            if (w_retire && w_isHalt) begin
               w_nextState = SYSC_ST_HALTED;
            end else if (w_retire && w_isPause) begin
               w_nextState = SYSC_ST_PAUSED;
            end
         end
         SYSC_ST_PAUSED: begin
`ifdef SYSCALL_PAUSE_EN
            if (resume) begin
               w_nextState = SYSC_ST_IDLE;
            end
`else
            w_nextState = SYSC_ST_IDLE;
`endif
         end
         SYSC_ST_HALTED: w_nextState = SYSC_ST_HALTED;
         default:        w_nextState = SYSC_ST_IDLE;
      endcase
   end

   always_comb begin
      stall  = 1'b0;
      halted = 1'b0;
      case (r_state)
         SYSC_ST_IDLE:   stall = syscall_en && w_isDisp && !w_accept;
         SYSC_ST_PAUSED: stall = 1'b1;
         SYSC_ST_HALTED: begin
            stall  = 1'b1;
            halted = 1'b1;
         end
         default: begin
            stall  = 1'b0;
            halted = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_syscallCnt <= '0;
      end else if (w_retire) begin
         r_syscallCnt <= r_syscallCnt + CNT_W'(1);
      end
   end

   assign syscall_cnt = r_syscallCnt;

endmodule

// File: tb/tb_syscall_responder.sv
// Self-checking bench for syscall_responder: directed scenarios followed by
// random traffic, all compared against a behavioural model of the syscall rules.
module tb_syscall_responder;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clock;
   logic              reset;
   logic              syscallEn;
   logic [DATA_W-1:0] v0;
   logic [DATA_W-1:0] a0;
   logic              resume;
   logic              dispReady;
   logic              stall;
   logic              halted;
   logic              dispValid;
   logic [DATA_W-1:0] dispData;
   logic [CNT_W-1:0]  syscallCnt;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state, expressed as the architectural effects of syscalls.
   bit          mHalted;
   bit          mPaused;
   bit          mValid;
   logic [31:0] mData;
   int          mCnt;

   syscall_responder #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clock),
      .rst         (reset),
      .syscall_en  (syscallEn),
      .v0          (v0),
      .a0          (a0),
      .resume      (resume),
      .disp_ready  (dispReady),
      .stall       (stall),
      .halted      (halted),
      .disp_valid  (dispValid),
      .disp_data   (dispData),
      .syscall_cnt (syscallCnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
      end
   endtask

   // One clock cycle: check registered outputs, drive inputs, check stall, advance model.
   task automatic applyStimulus(input bit r, input bit en, input logic [31:0] v, input logic [31:0] a,
                                input bit res, input bit rdy);
      bit expStall;
      bit retire;
      @(negedge clock);
      checkOutput("halted", {31'd0, halted}, {31'd0, mHalted});
      checkOutput("disp_valid", {31'd0, dispValid}, {31'd0, mValid});
      checkOutput("disp_data", dispData, mData);
      checkOutput("syscall_cnt", {28'd0, syscallCnt}, mCnt);
      reset     = r;
      syscallEn = en;
      v0        = v;
      a0        = a;
      resume    = res;
      dispReady = rdy;
      #1;
      expStall = mHalted || mPaused || (en && v == 32'd34 && mValid && !rdy);
      checkOutput("stall", {31'd0, stall}, {31'd0, expStall});
      if (r) begin
         mHalted = 0;
         mPaused = 0;
         mValid  = 0;
         mData   = 0;
         mCnt    = 0;
      end else begin
         retire = en && !mHalted && !mPaused && !expStall;
         if (retire && v == 32'd34) begin
            mValid = 1;
            mData  = a;
         end else if (mValid && rdy) begin
            mValid = 0;
         end
`ifdef SYSCALL_PAUSE_EN
         if (mPaused && res) mPaused = 0;
         if (retire && v == 32'd50) mPaused = 1;
`endif
         if (retire && v == 32'd10) mHalted = 1;
         if (retire) mCnt = (mCnt + 1) % 16;
      end
      @(posedge clock);
   endtask

   function automatic logic [31:0] randomCode();
      int pick = $urandom_range(0, 99);
      if (pick < 2)  return 32'd10;
      if (pick < 45) return 32'd34;
      if (pick < 55) return 32'd50;
      if (pick < 80) return 32'd7;
      return $urandom;
   endfunction

   initial begin
      mHalted = 0; mPaused = 0; mValid = 0; mData = 0; mCnt = 0;
      reset = 1'b1; syscallEn = 1'b0; v0 = '0; a0 = '0; resume = 1'b0; dispReady = 1'b0;
      applyStimulus(1, 1, 32'd34, 32'hDEAD, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Display with an always-ready driver.
      applyStimulus(0, 1, 32'd34, 32'h1234, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);

      // Back-pressure: hold 0xAAAA, block 0xBBBB for three cycles, then release.
      applyStimulus(0, 1, 32'd34, 32'hAAAA, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'd34, 32'hBBBB, 0, 0);
      applyStimulus(0, 1, 32'd34, 32'hBBBB, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Reset in the middle of a pending handshake.
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Pause code: stalls when the feature is built in, otherwise a no-op.
      applyStimulus(0, 1, 32'd50, 0, 0, 1);
      for (int i = 0; i < 19; i++) applyStimulus(0, 1, 32'd7, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);

      // Counter wrap over sixteen no-op syscalls.
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) applyStimulus(0, 1, 32'd7, 0, 0, 1);

      // Halt holds for 100 cycles regardless of resume, then reset clears it.
      applyStimulus(0, 1, 32'd10, 0, 0, 1);
      for (int i = 0; i < 100; i++) applyStimulus(0, $urandom_range(0, 1), 32'd34, $urandom, $urandom_range(0, 1), 1);
      applyStimulus(1, 1, 32'd10, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 99) < (mHalted ? 10 : 1)),
                       ($urandom_range(0, 9) < 7),
                       randomCode(), $urandom,
                       ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 1) == 1));
      end
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
